// File: rtl/pcm_framer_pkg.sv
// pcm_framer_pkg
// Shared definitions for the PCM framer: sample width, the streaming FSM
// state encoding and the width of the saturating overrun counter.
package pcm_framer_pkg;

    localparam int SAMPLE_W  = 16;
    localparam int OVR_CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SEND  = 2'd2
    } state_t;

endpackage

// File: rtl/pcm_framer_ram.sv
// framer_ram
// Simple dual-port sample buffer: one write port, one synchronous read
// port with one cycle of latency. A read of the address being written in
// the same cycle returns the old contents (read-before-write).
// Ports:
//   clk_i           clock
//   we_i, waddr_i,  write enable / address / data
//   wdata_i
//   re_i, raddr_i   read enable / address
//   rdata_o         registered read data, holds while re_i=0
module framer_ram
    import pcm_framer_pkg::*;
#(
    parameter int ADDR_W = 9,
    parameter int DATA_W = SAMPLE_W
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_o <= mem_q[raddr_i];
        end
    end

endmodule

// File: rtl/pcm_framer.sv
// pcm_framer
// Buffers decimated PCM samples in a circular buffer and, every HOP
// samples once FRAME_LEN samples are held, streams the newest FRAME_LEN
// samples (oldest first) as one frame. A single pending slot queues the
// next frame start; a newer trigger replaces an unserved one and that
// loss is reported on overrun / overrun_cnt.
// Ports:
//   clk, reset (async, active-low)
//   in_dv, in_dat           sample strobe and data, no back-pressure
//   out_valid, out_ready    output handshake
//   out_dat, out_first,     frame beat, first/last markers
//   out_last
//   overrun, overrun_cnt    discard pulse and saturating discard count
//   dbg_state               streaming FSM state
// Handshake: a beat transfers on a cycle where out_valid & out_ready are
// both 1; while out_valid=1 and out_ready=0, out_valid, out_dat,
// out_first and out_last hold their values.
module pcm_framer
    import pcm_framer_pkg::*;
#(
    parameter int FRAME_LEN = 256,
    parameter int HOP       = 128,
    parameter int ADDR_W    = 9
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_dv,
    input  logic [SAMPLE_W-1:0]  in_dat,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SAMPLE_W-1:0]  out_dat,
    output logic                 out_first,
    output logic                 out_last,
    output logic                 overrun,
    output logic [OVR_CNT_W-1:0] overrun_cnt,
    output state_t               dbg_state
);

    localparam int CNT_W = $clog2(FRAME_LEN) + 1;
    localparam int IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CNT_W-1:0]  FILL_FULL = CNT_W'(FRAME_LEN);
    localparam logic [CNT_W-1:0]  HOP_C     = CNT_W'(HOP);
    localparam logic [ADDR_W-1:0] FL_A      = ADDR_W'(FRAME_LEN);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(FRAME_LEN - 1);

    // Write side
    logic [ADDR_W-1:0]    wp_q, wp_d;
    logic [CNT_W-1:0]     fill_q, fill_d;
    logic [CNT_W-1:0]     hop_q, hop_d;
    logic                 trig;
    logic [ADDR_W-1:0]    trig_base;

    // Pending slot and overrun reporting
    logic                 pend_q, pend_d;
    logic [ADDR_W-1:0]    pbase_q, pbase_d;
    logic                 ovr_q, ovr_d;
    logic [OVR_CNT_W-1:0] ocnt_q, ocnt_d;

    // Streaming FSM
    state_t               state_q, state_d;
    logic [ADDR_W-1:0]    rp_q, rp_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 take;
    logic                 rd_en;
    logic [SAMPLE_W-1:0]  ram_rdata;

    always_comb begin
        wp_d   = wp_q;
        fill_d = fill_q;
        hop_d  = hop_q;
        trig   = 1'b0;
        if (in_dv) begin
            wp_d = wp_q + ADDR_W'(1);
            if (fill_q != FILL_FULL) begin
                fill_d = fill_q + CNT_W'(1);
                trig   = (fill_q + CNT_W'(1) == FILL_FULL);
            end else if (hop_q + CNT_W'(1) == HOP_C) begin
                hop_d = '0;
                trig  = 1'b1;
            end else begin
                hop_d = hop_q + CNT_W'(1);
            end
        end
        // Oldest of the newest FRAME_LEN samples, including this write.
        trig_base = wp_d - FL_A;
    end

    always_comb begin
        state_d = state_q;
        rp_d    = rp_q;
        idx_d   = idx_q;
        take    = 1'b0;
        rd_en   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pend_q) begin
                    rp_d    = pbase_q;
                    idx_d   = '0;
                    take    = 1'b1;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                rd_en   = 1'b1;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (out_ready) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_IDLE;
                    end else begin
                        rp_d    = rp_q + ADDR_W'(1);
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = ST_FETCH;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The FSM consumes the pending slot before a same-cycle trigger refills
    // it, so only a trigger landing on a still-unserved entry is a loss.
    always_comb begin
        pend_d  = (pend_q & ~take) | trig;
        pbase_d = trig ? trig_base : pbase_q;
        ovr_d   = trig & pend_q & ~take;
        ocnt_d  = (ovr_d && ocnt_q != '1) ? ocnt_q + OVR_CNT_W'(1) : ocnt_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp_q    <= '0;
            fill_q  <= '0;
            hop_q   <= '0;
            pend_q  <= 1'b0;
            pbase_q <= '0;
            ovr_q   <= 1'b0;
            ocnt_q  <= '0;
            state_q <= ST_IDLE;
            rp_q    <= '0;
            idx_q   <= '0;
        end else begin
            wp_q    <= wp_d;
            fill_q  <= fill_d;
            hop_q   <= hop_d;
            pend_q  <= pend_d;
            pbase_q <= pbase_d;
            ovr_q   <= ovr_d;
            ocnt_q  <= ocnt_d;
            state_q <= state_d;
            rp_q    <= rp_d;
            idx_q   <= idx_d;
        end
    end

    framer_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (SAMPLE_W)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (in_dv),
        .waddr_i (wp_q),
        .wdata_i (in_dat),
        .re_i    (rd_en),
        .raddr_i (rp_q),
        .rdata_o (ram_rdata)
    );

    // RAM output is not reset, so data is gated to keep outputs at 0
    // outside SEND (including straight after reset).
    assign out_valid   = (state_q == ST_SEND);
    assign out_dat     = out_valid ? ram_rdata : '0;
    assign out_first   = out_valid && (idx_q == '0);
    assign out_last    = out_valid && (idx_q == IDX_LAST);
    assign overrun     = ovr_q;
    assign overrun_cnt = ocnt_q;
    assign dbg_state   = state_q;

endmodule

// File: doc/pcm_framer.md
Name: pcm_framer

Overview:
- Sits between the PDM decimator (16-bit PCM plus a one-cycle `dv` strobe) and the neural-net word detector.
- Stores incoming PCM samples in a circular buffer.
- Every HOP samples, once the buffer holds FRAME_LEN samples, it streams one overlapping frame to the detector over a valid/ready interface.
- Each frame carries first/last markers.
- Frame-level overrun is reported when the detector falls behind.

Parameters:
- SAMPLE_W, 16: PCM sample width.
- FRAME_LEN, 256: samples per frame; power of two.
- HOP, 128: samples between frame starts; 1 <= HOP <= FRAME_LEN.
- ADDR_W, 9: buffer address width; depth 2**ADDR_W must be >= 2*FRAME_LEN.

Ports:
- clk, input, 1: single clock; all logic on posedge.
- reset, input, 1: asynchronous reset, active-low.
- in_dv, input, 1: one-cycle sample strobe from the decimator; no back-pressure.
- in_dat, input, SAMPLE_W: signed PCM sample, valid when in_dv=1.
- out_valid, output, 1: out_dat/out_first/out_last are valid.
- out_ready, input, 1: detector accepts the beat when out_valid & out_ready.
- out_dat, output, SAMPLE_W: frame sample, oldest first.
- out_first, output, 1: marks sample 0 of a frame.
- out_last, output, 1: marks sample FRAME_LEN-1 of a frame.
- overrun, output, 1: one-cycle pulse when a pending frame is discarded.
- overrun_cnt, output, 8: saturating count of discarded frames.

Behaviour:
- Reset (reset=0, asynchronous):
  - wp=0, fill=0, hop_cnt=0, pending=0, FSM=IDLE.
  - All outputs 0, overrun_cnt=0.
  - Buffer contents are don't-care.
  - Reset mid-frame aborts the frame with no last beat; warm-up restarts.
- Write side, on in_dv:
  - RAM[wp] <= in_dat; wp <= wp+1, wrapping mod 2**ADDR_W.
  - fill increments, saturating at FRAME_LEN.
  - hop_cnt counts once fill has reached FRAME_LEN.
- Frame trigger:
  - Asserted on the in_dv that makes fill reach FRAME_LEN (the first frame).
  - Thereafter asserted on every in_dv that makes hop_cnt reach HOP; hop_cnt then resets to 0.
  - Trigger base = (wp_after_write - FRAME_LEN) mod depth, i.e. the oldest of the newest FRAME_LEN samples.
- Pending slot (depth 1):
  - A trigger loads pending_base and sets pending=1.
  - If pending=1 already, the old pending base is replaced by the new one, overrun pulses for 1 cycle, and overrun_cnt increments (saturating at 255).
  - The frame currently being streamed is never aborted.
- FSM:
  - IDLE: if pending, rp <= pending_base, idx <= 0, pending <= 0 → FETCH.
  - FETCH: RAM read issued at rp (synchronous read, 1-cycle latency) → SEND.
  - SEND: out_valid=1 with the registered RAM data.
    - out_first = (idx==0); out_last = (idx==FRAME_LEN-1).
    - out_valid/out_dat hold stable until out_ready.
    - On handshake, if not last: rp++, idx++ → FETCH.
    - On handshake, if last → IDLE.
- Throughput and latency:
  - Maximum one beat per 2 cycles.
  - Trigger to first out_valid: 3 cycles when IDLE (pending set, IDLE→FETCH, FETCH→SEND).
- Simultaneous events:
  - A trigger in the same cycle that IDLE consumes pending: pending is consumed first, then the new trigger sets pending. No overrun.
  - in_dv during FETCH/SEND: the write proceeds; RAM is dual-port.
  - Same-address read/write returns old data.
- Consumer requirement: each frame must be drained within (depth - FRAME_LEN) input samples. Otherwise the data is overwritten silently; this case is not detected.
- No arithmetic on sample values; samples pass bit-exact.

Decomposition:
- Shared package:
  - SAMPLE_W.
  - FSM state encoding (IDLE=0, FETCH=1, SEND=2).
  - Overrun counter width (8).
- Sub-module `framer_ram`:
  - Simple dual-port RAM, 2**ADDR_W x SAMPLE_W.
  - One write port, one synchronous read port, read-before-write.
  - Inferable as block RAM.

Test Plan (bench params FRAME_LEN=8, HOP=4, ADDR_W=4 unless noted):
- Warm-up: in_dv with samples 1..8 every 10 cycles, out_ready=1.
  - Exactly one frame, beats 1..8, out_first on 1, out_last on 8.
  - First out_valid 3 cycles after the 8th in_dv.
  - No frame before sample 8.
- Overlap: continue with samples 9..16.
  - Frames 5..12, then 9..16.
  - Beat spacing 2 cycles; overrun stays 0.
- Back-pressure: out_ready toggling 1/0 randomly.
  - out_dat/out_first/out_last stable while out_valid & !out_ready.
  - Sequence identical to the out_ready=1 run.
- Overrun: out_ready=0 while samples 1..16 arrive.
  - Frame 1..8 stays in SEND; frame 5..12 becomes pending.
  - Trigger at 16 replaces it: overrun pulses once, overrun_cnt=1.
  - After out_ready=1: frames 1..8, then 9..16.
- Wrap-around: 40 samples with ramp values; address wraps twice.
  - Every frame is contiguous and correct across the wp wrap.
- Reset mid-frame: assert reset low during beat 4 of a frame.
  - All outputs 0 immediately (asynchronous).
  - After release, no output until 8 new samples arrive; overrun_cnt=0.
